// File: rtl/cpu_result_checker.sv
// ---------------------------------------------------------------------------
// cpu_result_checker
//   Self-check monitor for the single-cycle CPU. It snoops the register-file
//   write port and the program counter, decides when the program has finished,
//   and then compares a small table of watched registers against expected
//   values. The result is pass/fail, a per-slot fail mask and a cycle count.
//
//   A program is finished when it halts or when it times out:
//     - Halt: PC has been unchanged for HALT_STABLE consecutive cycles.
//       A jump-to-self loop produces this.
//     - Timeout: TIMEOUT_CYCLES cycles have been spent in RUN.
//
//   Optional feature (build macro CHECKER_FIRST_FAIL_EN):
//     defined     -> first_fail holds the lowest failing slot index, or
//                    8'hFF if no slot fails.
//     not defined -> first_fail is tied to 0 and no capture logic is built.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   start      in   pulse: clear all state and enter RUN on the next edge
//   pc         in   CPU program counter
//   rf_we      in   register-file write enable
//   rf_waddr   in   register-file write address
//   rf_wdata   in   register-file write data
//   exp_addr   in   slot i watched address  = exp_addr[i*ADDR_WIDTH +: ADDR_WIDTH]
//   exp_data   in   slot i expected value   = exp_data[i*DATA_WIDTH +: DATA_WIDTH]
//   done       out  high once checking has finished
//   passed     out  1 when done, every slot matched and there was no timeout
//   timeout    out  RUN was ended by the timeout
//   fail_mask  out  bit i set = slot i mismatched
//   cycle_cnt  out  cycles spent in RUN (saturating)
//   first_fail out  lowest failing slot index (see macro above)
// ---------------------------------------------------------------------------
module cpu_result_checker #(
  parameter int NUM_CHECKS     = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int HALT_STABLE    = 3,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [31:0]                      pc,
  input  logic                             rf_we,
  input  logic [ADDR_WIDTH-1:0]            rf_waddr,
  input  logic [DATA_WIDTH-1:0]            rf_wdata,
  input  logic [NUM_CHECKS*ADDR_WIDTH-1:0] exp_addr,
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0] exp_data,
  output logic                             done,
  output logic                             passed,
  output logic                             timeout,
  output logic [NUM_CHECKS-1:0]            fail_mask,
  output logic [CNT_WIDTH-1:0]             cycle_cnt,
  output logic [7:0]                       first_fail
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam int STB_W = $clog2(HALT_STABLE);

  localparam logic [IDX_W-1:0]      IDX_LAST     = IDX_W'(NUM_CHECKS - 1);
  localparam logic [IDX_W-1:0]      IDX_ZERO     = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]      IDX_ONE      = IDX_W'(1);
  localparam logic [STB_W-1:0]      STABLE_LAST  = STB_W'(HALT_STABLE - 1);
  localparam logic [STB_W-1:0]      STB_ZERO     = {STB_W{1'b0}};
  localparam logic [STB_W-1:0]      STB_ONE      = STB_W'(1);
  localparam logic [CNT_WIDTH-1:0]  TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO     = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE      = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO    = {ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO    = {DATA_WIDTH{1'b0}};
  localparam logic [NUM_CHECKS-1:0] MASK_ZERO    = {NUM_CHECKS{1'b0}};

  logic [1:0]            state_r;
  logic [31:0]           prev_pc_r;
  logic [STB_W-1:0]      stable_r;
  logic [IDX_W-1:0]      check_idx_r;
  logic [DATA_WIDTH-1:0] shadow_r [NUM_CHECKS];

  logic [ADDR_WIDTH-1:0] exp_addr_a_s [NUM_CHECKS];
  logic [DATA_WIDTH-1:0] exp_data_a_s [NUM_CHECKS];
  logic [NUM_CHECKS-1:0] shadow_hit_s;
  logic [NUM_CHECKS-1:0] mask_upd_s;
  logic                  mismatch_s;
  logic                  halt_s;
  logic                  tmo_s;
  logic                  cnt_sat_s;

  // Unpack the flat expected-table buses into per-slot arrays.
  genvar g;
  generate
    for (g = 0; g < NUM_CHECKS; g++) begin : g_slot
      assign exp_addr_a_s[g] = exp_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign exp_data_a_s[g] = exp_data[g*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Decode shadow hits, the current slot compare, and the halt/timeout conditions.
  always_comb begin
    shadow_hit_s = MASK_ZERO;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      // r0 is hard-wired zero in the CPU, so writes to it never reach a shadow.
      shadow_hit_s[i] = rf_we && (rf_waddr != ADDR_ZERO) && (rf_waddr == exp_addr_a_s[i]);
    end
    mismatch_s              = (shadow_r[check_idx_r] != exp_data_a_s[check_idx_r]);
    mask_upd_s              = fail_mask;
    mask_upd_s[check_idx_r] = mismatch_s;
    halt_s                  = (stable_r == STABLE_LAST);
    tmo_s                   = (cycle_cnt == TIMEOUT_LAST);
    cnt_sat_s               = &cycle_cnt;
  end

  // Main FSM: RUN monitoring, slot-by-slot CHECK, and result latching.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      prev_pc_r   <= 32'h0000_0000;
      stable_r    <= STB_ZERO;
      check_idx_r <= IDX_ZERO;
      done        <= 1'b0;
      passed      <= 1'b0;
      timeout     <= 1'b0;
      fail_mask   <= MASK_ZERO;
      cycle_cnt   <= CNT_ZERO;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        shadow_r[i] <= DATA_ZERO;
      end
    end else begin
      prev_pc_r <= pc;
      if (start) begin
        state_r     <= ST_RUN;
        stable_r    <= STB_ZERO;
        check_idx_r <= IDX_ZERO;
        done        <= 1'b0;
        passed      <= 1'b0;
        timeout     <= 1'b0;
        fail_mask   <= MASK_ZERO;
        cycle_cnt   <= CNT_ZERO;
        for (int i = 0; i < NUM_CHECKS; i++) begin
          shadow_r[i] <= DATA_ZERO;
        end
      end else begin
        case (state_r)
          ST_RUN: begin
            if (!cnt_sat_s) begin
              cycle_cnt <= cycle_cnt + CNT_ONE;
            end
            if (pc == prev_pc_r) begin
              stable_r <= stable_r + STB_ONE;
            end else begin
              stable_r <= STB_ZERO;
            end
            // A write in the cycle that ends RUN is still captured.
            for (int i = 0; i < NUM_CHECKS; i++) begin
              if (shadow_hit_s[i]) begin
                shadow_r[i] <= rf_wdata;
              end
            end
            // Timeout wins over halt when both fire in the same cycle.
            if (tmo_s || halt_s) begin
              state_r     <= ST_CHECK;
              timeout     <= tmo_s;
              check_idx_r <= IDX_ZERO;
            end
          end
          ST_CHECK: begin
            fail_mask <= mask_upd_s;
            if (check_idx_r == IDX_LAST) begin
              state_r <= ST_DONE;
              done    <= 1'b1;
              // Include the final slot compare, which is not yet in fail_mask.
              passed  <= (mask_upd_s == MASK_ZERO) && !timeout;
            end else begin
              check_idx_r <= check_idx_r + IDX_ONE;
            end
          end
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_DONE: begin
            state_r <= ST_DONE;
          end
          default: begin
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef CHECKER_FIRST_FAIL_EN
  // Latch the lowest failing slot; 8'hFF means no failure has been seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      first_fail <= 8'h00;
    end else if (start) begin
      first_fail <= 8'hFF;
    end else if ((state_r == ST_CHECK) && mismatch_s && (first_fail == 8'hFF)) begin
      first_fail <= 8'(check_idx_r);
    end
  end
`else
  assign first_fail = 8'h00;
`endif

endmodule

// File: tb/tb_cpu_result_checker.sv
module tb_cpu_result_checker;

  logic         clk;
  logic         reset;
  logic         start;
  logic [31:0]  pc;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic [19:0]  exp_addr;
  logic [127:0] exp_data;
  logic         done;
  logic         passed;
  logic         timeout;
  logic [3:0]   fail_mask;
  logic [15:0]  cycle_cnt;
  logic [7:0]   first_fail;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_wait = 0;

`ifdef CHECKER_FIRST_FAIL_EN
  localparam logic [7:0] FF_NONE = 8'hFF;
  localparam logic [7:0] FF_ONE  = 8'h01;
`else
  localparam logic [7:0] FF_NONE = 8'h00;
  localparam logic [7:0] FF_ONE  = 8'h00;
`endif

  cpu_result_checker dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pc         (pc),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .exp_addr   (exp_addr),
    .exp_data   (exp_data),
    .done       (done),
    .passed     (passed),
    .timeout    (timeout),
    .fail_mask  (fail_mask),
    .cycle_cnt  (cycle_cnt),
    .first_fail (first_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] p, input logic we, input logic [4:0] a, input logic [31:0] d);
    pc       = p;
    rf_we    = we;
    rf_waddr = a;
    rf_wdata = d;
  endtask

  task automatic set_slot(input int i, input logic [4:0] a, input logic [31:0] d);
    exp_addr[i*5 +: 5]   = a;
    exp_data[i*32 +: 32] = d;
  endtask

  task automatic do_start();
    drive(32'h0, 1'b0, 5'd0, 32'h0);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  // Writes r2=5, r2=270, r3=r3v while PC moves, then PC parks at 0x40.
  // Halt fires in the 7th RUN cycle, which also writes r4=0x55; the 8th
  // cycle (already in CHECK) writes r5=1, which must not be captured.
  task automatic run_prog(input logic [31:0] r3v);
    drive(32'h04, 1'b1, 5'd2, 32'd5);    step();
    drive(32'h08, 1'b1, 5'd2, 32'd270);  step();
    drive(32'h0C, 1'b1, 5'd3, r3v);      step();
    drive(32'h40, 1'b0, 5'd0, 32'h0);    step(); step(); step();
    drive(32'h40, 1'b1, 5'd4, 32'h55);   step();
    drive(32'h40, 1'b1, 5'd5, 32'd1);    step();
    drive(32'h40, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    drive(32'h0, 1'b0, 5'd0, 32'h0);
    exp_addr = 20'h0;
    exp_data = 128'h0;
    step(); step();

    // Reset state
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_passed", {31'd0, passed}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_mask", {28'd0, fail_mask}, 32'd0);
    chk("rst_cnt", {16'd0, cycle_cnt}, 32'd0);
    chk("rst_ff", {24'd0, first_fail}, 32'd0);
    reset = 1'b0;
    step(); step();
    chk("idle_cnt", {16'd0, cycle_cnt}, 32'd0);

    // Test 1: all slots match, halt by jump-to-self
    set_slot(0, 5'd2, 32'd270);
    set_slot(1, 5'd3, 32'd7);
    set_slot(2, 5'd4, 32'h55);
    set_slot(3, 5'd5, 32'd0);
    do_start();
    run_prog(32'd7);
    chk("t1_done_early", {31'd0, done}, 32'd0);
    wait_done(n_wait);
    chk("t1_latency", n_wait, 32'd3);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_passed", {31'd0, passed}, 32'd1);
    chk("t1_mask", {28'd0, fail_mask}, 32'd0);
    chk("t1_timeout", {31'd0, timeout}, 32'd0);
    chk("t1_cnt", {16'd0, cycle_cnt}, 32'd7);
    chk("t1_ff", {24'd0, first_fail}, {24'd0, FF_NONE});
    drive(32'h44, 1'b1, 5'd2, 32'd9);
    step(); step(); step();
    chk("t1_hold_done", {31'd0, done}, 32'd1);
    chk("t1_hold_passed", {31'd0, passed}, 32'd1);
    chk("t1_hold_cnt", {16'd0, cycle_cnt}, 32'd7);

    // Test 6 + 2: restart from DONE, slot1 mismatch (r3 written 8)
    do_start();
    chk("t6_done", {31'd0, done}, 32'd0);
    chk("t6_passed", {31'd0, passed}, 32'd0);
    chk("t6_cnt", {16'd0, cycle_cnt}, 32'd0);
    step();
    chk("t6_cnt_run", {16'd0, cycle_cnt}, 32'd1);
    do_start();
    run_prog(32'd8);
    wait_done(n_wait);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_passed", {31'd0, passed}, 32'd0);
    chk("t2_mask", {28'd0, fail_mask}, 32'h2);
    chk("t2_ff", {24'd0, first_fail}, {24'd0, FF_ONE});
    chk("t2_timeout", {31'd0, timeout}, 32'd0);

    // Test 3: PC never stable -> timeout after 100 RUN cycles
    set_slot(0, 5'd2, 32'd0);
    set_slot(1, 5'd3, 32'd0);
    set_slot(2, 5'd4, 32'd0);
    set_slot(3, 5'd5, 32'd0);
    do_start();
    for (int i = 1; i <= 99; i++) begin
      drive(32'(i * 4), 1'b0, 5'd0, 32'h0);
      step();
    end
    chk("t3_cnt99", {16'd0, cycle_cnt}, 32'd99);
    chk("t3_to_early", {31'd0, timeout}, 32'd0);
    drive(32'd400, 1'b0, 5'd0, 32'h0);
    step();
    chk("t3_timeout", {31'd0, timeout}, 32'd1);
    chk("t3_cnt100", {16'd0, cycle_cnt}, 32'd100);
    chk("t3_done_early", {31'd0, done}, 32'd0);
    wait_done(n_wait);
    chk("t3_latency", n_wait, 32'd4);
    chk("t3_done", {31'd0, done}, 32'd1);
    chk("t3_passed", {31'd0, passed}, 32'd0);
    chk("t3_mask", {28'd0, fail_mask}, 32'd0);
    chk("t3_ff", {24'd0, first_fail}, {24'd0, FF_NONE});

    // Test 4: address 0 slots and duplicate addresses
    set_slot(0, 5'd0, 32'd0);
    set_slot(1, 5'd0, 32'd1);
    set_slot(2, 5'd6, 32'd9);
    set_slot(3, 5'd6, 32'd10);
    do_start();
    drive(32'h04, 1'b1, 5'd0, 32'hFFFF); step();
    drive(32'h08, 1'b1, 5'd6, 32'd9);    step();
    drive(32'h40, 1'b0, 5'd0, 32'h0);
    wait_done(n_wait);
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_mask", {28'd0, fail_mask}, 32'hA);
    chk("t4_passed", {31'd0, passed}, 32'd0);
    chk("t4_ff", {24'd0, first_fail}, {24'd0, FF_ONE});

    // Test 5: reset mid-CHECK, then a clean rerun
    set_slot(0, 5'd2, 32'd270);
    set_slot(1, 5'd3, 32'd7);
    set_slot(2, 5'd4, 32'h55);
    set_slot(3, 5'd5, 32'd0);
    do_start();
    run_prog(32'd8);
    step();
    chk("t5_mask_mid", {28'd0, fail_mask}, 32'h2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_done", {31'd0, done}, 32'd0);
    chk("t5_mask", {28'd0, fail_mask}, 32'd0);
    chk("t5_cnt", {16'd0, cycle_cnt}, 32'd0);
    chk("t5_ff", {24'd0, first_fail}, 32'd0);
    step(); step(); step();
    chk("t5_idle_done", {31'd0, done}, 32'd0);
    do_start();
    run_prog(32'd7);
    wait_done(n_wait);
    chk("t5_rerun_done", {31'd0, done}, 32'd1);
    chk("t5_rerun_passed", {31'd0, passed}, 32'd1);
    chk("t5_rerun_cnt", {16'd0, cycle_cnt}, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
